// File: rtl/lifo_param.sv
// lifo_param: single-clock stack/queue buffer with runtime LIFO/FIFO mode,
// occupancy count, empty/full flags, registered pop data and error pulses.
module lifo_param #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] datain,
  input  logic             read,
  input  logic             mode,
  output logic [WIDTH-1:0] dataout,
  output logic             val,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             udf
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wp, r_rp;
  logic             r_mode;   // 1 = FIFO
  logic [WIDTH-1:0] r_dout;
  logic             r_val, r_ovf, r_udf;

  logic          w_empty, w_full, w_fifo;
  logic          w_pop, w_push;
  logic [PW-1:0] w_top, w_waddr, w_raddr;

  // Pointer advance with explicit wrap so DEPTH need not be a power of 2.
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  // While empty the incoming mode applies to this edge's write.
  assign w_fifo  = w_empty ? mode : r_mode;
  assign w_top   = PW'(r_count - CW'(1));
  // A pop needs data; a push is accepted unless full without a matching pop.
  assign w_pop   = read & ~w_empty;
  assign w_push  = write & (~w_full | w_pop);

  // Address selection: empty writes land in slot 0 for both modes; a LIFO
  // push+pop overwrites the top slot it just read.
  always_comb begin
    w_waddr = '0;
    w_raddr = '0;
    if (w_fifo) begin
      w_raddr = r_rp;
      if (!w_empty) w_waddr = r_wp;
    end else begin
      w_raddr = w_top;
      if (!w_empty) w_waddr = w_pop ? w_top : PW'(r_count);
    end
  end

  // Storage array: written on accepted pushes, never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_waddr] <= datain;
  end

  // Control state, count, pointers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_mode  <= 1'b0;
      r_dout  <= '0;
      r_val   <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_val <= w_pop;
      r_ovf <= write & ~w_push;
      r_udf <= read & w_empty;
      if (w_pop) r_dout <= r_mem[w_raddr];

      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);

      if (w_empty) begin
        r_mode <= mode;
        r_rp   <= '0;
        r_wp   <= (w_push && mode) ? PW'(1) : '0;
      end else if (r_mode) begin
        if (w_push) r_wp <= f_inc(r_wp);
        if (w_pop)  r_rp <= f_inc(r_rp);
      end
    end
  end

  assign dataout = r_dout;
  assign val     = r_val;
  assign ovf     = r_ovf;
  assign udf     = r_udf;
  assign count   = r_count;
  assign full    = w_full;
  assign empty   = w_empty;

endmodule

// File: tb/tb_lifo_param.sv
// Bench for lifo_param: directed scenarios plus random traffic, checked by a
// queue-based reference model and a negedge monitor with a pop scoreboard.
module tb_lifo_param;
  localparam int WIDTH = 10;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 0, reset = 0, write = 0, read = 0, mode = 0;
  logic [WIDTH-1:0] datain = '0;
  logic [WIDTH-1:0] dataout;
  logic             val, full, empty, ovf, udf;
  logic [CW-1:0]    count;

  lifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .write(write), .datain(datain), .read(read),
    .mode(mode), .dataout(dataout), .val(val), .full(full), .empty(empty),
    .count(count), .ovf(ovf), .udf(udf));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference model: contents in arrival order, active mode, expected pulses.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               mmode = 0;
  bit               e_val = 0, e_ovf = 0, e_udf = 0;
  logic [WIDTH-1:0] e_dout = '0;
  bit               mon_en = 0;
  bit               cur_mode = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, then advance the model by what that edge should do.
  task automatic apply(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit m);
    logic [WIDTH-1:0] v;
    write = w; read = r; datain = d; mode = m;
    @(posedge clk);
    e_val = 0; e_ovf = 0; e_udf = 0;
    if (mq.size() == 0) begin
      mmode = m;
      if (r) e_udf = 1;
      if (w) mq.push_back(d);
    end else begin
      if (r) begin
        v = mmode ? mq.pop_front() : mq.pop_back();
        exp_q.push_back(v);
        e_val = 1;
        e_dout = v;
      end
      if (w) begin
        if (mq.size() == DEPTH) e_ovf = 1;
        else mq.push_back(d);
      end
    end
    #1;
    write = 0; read = 0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d); apply(1, 0, d, cur_mode); endtask
  task automatic pop();                            apply(0, 1, '0, cur_mode); endtask

  // Monitor: compare flags every cycle; pop the scoreboard on each val.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full",  full,  mq.size() == DEPTH);
      chk("ovf",   ovf,   e_ovf);
      chk("udf",   udf,   e_udf);
      chk("val",   val,   e_val);
      chk("dataout_hold", dataout, e_dout);
      if (val) begin
        if (exp_q.size() == 0) chk("unexpected_val", 1, 0);
        else chk("pop_data", dataout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1 reset = 1;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    chk("rst_dout",  dataout, 0);
    chk("rst_val",   val, 0);
    chk("rst_ovf",   ovf, 0);
    chk("rst_udf",   udf, 0);
    @(posedge clk); #1 reset = 0; mon_en = 1;

    // 1: LIFO ordering
    push(10'h001); push(10'h002); push(10'h004);
    pop(); pop(); pop();
    // 2: fill, overflow, pop top
    for (int i = 1; i <= 8; i++) push(10'(i));
    push(10'h3FF);
    pop();
    while (mq.size() > 0) pop();
    // 3: FIFO selected while empty; mode change while occupied ignored
    cur_mode = 1;
    push(10'h011); push(10'h022);
    cur_mode = 0;
    push(10'h033);
    pop(); pop(); pop();
    // 4: FIFO wrap
    cur_mode = 1;
    for (int i = 0; i < 8; i++) push(10'(10'h100 + i));
    pop(); pop(); pop();
    push(10'h1A0); push(10'h1A1); push(10'h1A2);
    for (int i = 0; i < 8; i++) pop();
    // 5: LIFO simultaneous read+write, then underflow
    cur_mode = 0;
    push(10'h001); push(10'h002); push(10'h004);
    apply(1, 1, 10'h16B, 0);
    pop(); pop(); pop(); pop();
    apply(1, 1, 10'h055, 0);   // empty: write taken, read flagged
    pop();
    // full with simultaneous read+write in both modes
    for (int i = 0; i < 8; i++) push(10'(10'h200 + i));
    apply(1, 1, 10'h2FF, 0);
    while (mq.size() > 0) pop();
    cur_mode = 1;
    for (int i = 0; i < 8; i++) push(10'(10'h240 + i));
    apply(1, 1, 10'h2EE, 1);
    while (mq.size() > 0) pop();
    // 6: reset mid-operation, half a cycle after an edge
    cur_mode = 0;
    for (int i = 0; i < 5; i++) push(10'(10'h300 + i));
    mon_en = 0;
    #4 reset = 1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_dout",  dataout, 0);
    chk("mid_rst_val",   val, 0);
    mq.delete(); exp_q.delete();
    e_dout = '0; e_val = 0; e_ovf = 0; e_udf = 0;
    @(posedge clk); #1 reset = 0; mon_en = 1;
    pop();

    // Random traffic with phases biased toward filling or draining.
    for (int i = 0; i < 1200; i++) begin
      int wp, rp;
      wp = ((i / 100) % 2 == 0) ? 70 : 35;
      rp = 100 - wp;
      if ($urandom_range(0, 99) < 8) cur_mode = ~cur_mode;
      apply($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
            10'($urandom), cur_mode);
    end
    while (mq.size() > 0) pop();
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
